// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle shared by the timing generator and every draw stage.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 1024x768@60) with start-of-frame pulse.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 1024,
   parameter int   H_FP     = 24,
   parameter int   H_SYNC   = 136,
   parameter int   H_BP     = 160,
   parameter int   V_ACTIVE = 768,
   parameter int   V_FP     = 3,
   parameter int   V_SYNC   = 6,
   parameter int   V_BP     = 29,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   vga_if.out          vout,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOT > 2048) begin : g_htot_chk
      $fatal(1, "vga_timing_gen: H_TOT exceeds 11-bit counter range");
   end
   if (V_TOT > 2048) begin : g_vtot_chk
      $fatal(1, "vga_timing_gen: V_TOT exceeds 11-bit counter range");
   end

   localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
   localparam logic [10:0] H_BLK  = 11'(H_ACTIVE);
   localparam logic [10:0] V_BLK  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic        h_end, v_end, wrap;
   logic [10:0] h_nxt, v_nxt;

   always_comb begin
      h_end = (vout.hcount == H_LAST);
      v_end = (vout.vcount == V_LAST);
      wrap  = h_end & v_end;
      h_nxt = h_end ? 11'd0 : vout.hcount + 11'd1;
      v_nxt = vout.vcount;
      if (h_end)
         v_nxt = v_end ? 11'd0 : vout.vcount + 11'd1;
   end

   // Sync/blank decode the next counts so all fields land on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vout.hcount <= 11'd0;
         vout.vcount <= 11'd0;
         vout.hblnk  <= 1'b0;
         vout.vblnk  <= 1'b0;
         vout.hsync  <= ~SYNC_POL;
         vout.vsync  <= ~SYNC_POL;
         frame_start <= 1'b0;
      end else if (en) begin
         vout.hcount <= h_nxt;
         vout.vcount <= v_nxt;
         vout.hblnk  <= (h_nxt >= H_BLK);
         vout.vblnk  <= (v_nxt >= V_BLK);
         vout.hsync  <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? SYNC_POL : ~SYNC_POL;
         vout.vsync  <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? SYNC_POL : ~SYNC_POL;
         frame_start <= wrap;
      end else begin
         frame_start <= 1'b0;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_cnt_q <= 16'h0000;
      else if (en && wrap)
         frame_cnt_q <= frame_cnt_q + 16'h0001;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen using a reduced geometry; the reference
// model derives every output from the number of enabled cycles since reset.
module tb_vga_timing_gen;

   localparam int   HA = 16, HF = 4, HS = 6, HB = 6;
   localparam int   VA = 12, VF = 2, VS = 3, VB = 3;
   localparam int   HT = HA + HF + HS + HB;   // 32
   localparam int   VT = VA + VF + VS + VB;   // 20
   localparam int   FRAME = HT * VT;          // 640
   localparam logic SP = 1'b0;

   logic        clk = 1'b0;
   logic        rst, en;
   logic        frame_start;
   logic [15:0] frame_cnt;
   vga_if       vif ();

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(SP)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .vout(vif),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int   total = 0, bad = 0;
   int   n = 0;        // enabled edges since last reset
   int   fc = 0;       // frame wraps since last reset
   logic fs_exp = 1'b0;

   logic [42:0] obs;
   assign obs = {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk,
                 frame_start, frame_cnt};

   function automatic logic [15:0] fc_want();
`ifdef VGA_TIMING_FRAME_CNT_EN
      return 16'(fc);
`else
      return 16'h0000;
`endif
   endfunction

   // Expected outputs after k enabled cycles, straight from the raster rules.
   function automatic logic [42:0] model(input int k, input logic fs, input logic [15:0] cnt);
      int h, v;
      logic hs, vs, hb, vb;
      h  = k % HT;
      v  = (k / HT) % VT;
      hb = (h >= HA);
      vb = (v >= VA);
      hs = (h >= HA + HF && h < HA + HF + HS) ? SP : ~SP;
      vs = (v >= VA + VF && v < VA + VF + VS) ? SP : ~SP;
      return {11'(h), 11'(v), hs, vs, hb, vb, fs, cnt};
   endfunction

   task automatic tick(input logic e);
      en = e;
      @(posedge clk);
      if (e) n++;
      fs_exp = e && (n % FRAME == 0);
      if (fs_exp) fc++;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      n = 0; fc = 0; fs_exp = 1'b0;
      total++;
      if (obs !== model(0, 1'b0, 16'h0)) begin
         bad++; $display("FAIL reset_held got=%h want=%h", obs, model(0, 1'b0, 16'h0));
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (obs !== model(0, 1'b0, 16'h0)) begin
         bad++; $display("FAIL reset_release got=%h want=%h", obs, model(0, 1'b0, 16'h0));
      end
      tick(1'b1);
      total++;
      if (vif.hcount !== 11'd1) begin
         bad++; $display("FAIL first_edge hcount got=%0d want=1", vif.hcount);
      end
   endtask

   task automatic test_frames();
      int last_fs, vs_low, cyc;
      last_fs = -1; vs_low = 0; cyc = 0;
      repeat (2 * FRAME + 40) begin
         tick(1'b1);
         cyc++;
         total++;
         if (obs !== model(n, fs_exp, fc_want())) begin
            bad++; $display("FAIL frame_sweep n=%0d got=%h want=%h", n, obs, model(n, fs_exp, fc_want()));
         end
         if (vif.vsync === SP && n > FRAME && n <= 2 * FRAME) vs_low++;
         if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
               total++;
               if (cyc - last_fs !== FRAME) begin
                  bad++; $display("FAIL fs_period got=%0d want=%0d", cyc - last_fs, FRAME);
               end
            end
            last_fs = cyc;
         end
      end
      total++;
      if (vs_low !== VS * HT) begin
         bad++; $display("FAIL vsync_width got=%0d want=%0d", vs_low, VS * HT);
      end
   endtask

   task automatic test_en_hold();
      while (n % HT != HA + HF - 1) tick(1'b1);
      repeat (5) begin
         tick(1'b0);
         total++;
         if (obs !== model(n, 1'b0, fc_want()) || vif.hsync !== ~SP) begin
            bad++; $display("FAIL en_freeze got=%h want=%h", obs, model(n, 1'b0, fc_want()));
         end
      end
      tick(1'b1);
      total++;
      if (vif.hsync !== SP || obs !== model(n, fs_exp, fc_want())) begin
         bad++; $display("FAIL en_resume got=%h want=%h", obs, model(n, fs_exp, fc_want()));
      end
      while (n % FRAME != FRAME - 1) tick(1'b1);
      repeat (5) begin
         tick(1'b0);
         total++;
         if (frame_start !== 1'b0 || obs !== model(n, 1'b0, fc_want())) begin
            bad++; $display("FAIL fs_while_disabled got=%h want=%h", obs, model(n, 1'b0, fc_want()));
         end
      end
      tick(1'b1);
      total++;
      if (frame_start !== 1'b1 || obs !== model(n, 1'b1, fc_want())) begin
         bad++; $display("FAIL fs_after_enable got=%h want=%h", obs, model(n, 1'b1, fc_want()));
      end
   endtask

   task automatic test_random_en();
      repeat (1800) begin
         tick($urandom_range(0, 3) != 0);
         total++;
         if (obs !== model(n, fs_exp, fc_want())) begin
            bad++; $display("FAIL random_en n=%0d got=%h want=%h", n, obs, model(n, fs_exp, fc_want()));
         end
      end
   endtask

   task automatic test_async_rst();
      int first_fs;
      while (n % FRAME != (VA / 2) * HT + HA / 2) tick(1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n = 0; fc = 0; fs_exp = 1'b0;
      total++;
      if (obs !== model(0, 1'b0, 16'h0)) begin
         bad++; $display("FAIL async_rst got=%h want=%h", obs, model(0, 1'b0, 16'h0));
      end
      @(negedge clk);
      rst = 1'b0;
      first_fs = -1;
      for (int i = 1; i <= FRAME + 5; i++) begin
         tick(1'b1);
         total++;
         if (obs !== model(n, fs_exp, fc_want())) begin
            bad++; $display("FAIL post_rst n=%0d got=%h want=%h", n, obs, model(n, fs_exp, fc_want()));
         end
         if (frame_start === 1'b1 && first_fs < 0) first_fs = i;
      end
      total++;
      if (first_fs !== FRAME) begin
         bad++; $display("FAIL post_rst_first_fs got=%0d want=%0d", first_fs, FRAME);
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_en_hold();
      test_random_en();
      test_async_rst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
